// File: rtl/csr_timer.sv
// Constant timer (TCFG/TVAL countdown with latched interrupt) and the 64-bit
// free-running stable counter read by the rdcnt* instructions.
module csr_timer #(
  parameter int TIMER_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tcfg_we,
  input  logic [31:0] tcfg_wdata,
  input  logic        ticlr_we,
  input  logic [31:0] ticlr_wdata,
  output logic [31:0] tcfg_out,
  output logic [31:0] tval_out,
  output logic        ti_out,
  output logic [63:0] stable_cnt
);

  logic [31:0]        tcfg_reg;
  logic [31:0]        tcfg_wmask;
  logic [TIMER_W-1:0] tval_reg, tval_next;
  logic [TIMER_W-1:0] reload, wr_reload;
  logic               stopped_reg, stopped_next;
  logic               ti_reg, ti_next;
  logic [63:0]        cnt_reg;
  logic               active, expire;
  logic               unused_bits;

  // Bits at or above TIMER_W store 0 and read back as 0.
  for (genvar gi = 0; gi < 32; gi++) begin : g_bits
    if (gi < TIMER_W) begin : g_impl
      assign tcfg_wmask[gi] = tcfg_wdata[gi];
      assign tval_out[gi]   = tval_reg[gi];
    end else begin : g_zero
      assign tcfg_wmask[gi] = 1'b0;
      assign tval_out[gi]   = 1'b0;
    end
  end

  assign unused_bits = ^{tcfg_wdata, ticlr_wdata[31:1]};

  assign reload    = {tcfg_reg[TIMER_W-1:2], 2'b00};
  assign wr_reload = {tcfg_wdata[TIMER_W-1:2], 2'b00};
  assign active    = tcfg_reg[0] & ~stopped_reg;
  // A TCFG write suppresses the expiry that would otherwise happen this cycle.
  assign expire    = ~tcfg_we & active & (tval_reg == '0);

  always_comb begin
    tval_next    = tval_reg;
    stopped_next = stopped_reg;
    if (tcfg_we) begin
      tval_next    = wr_reload;
      stopped_next = 1'b0;
    end else if (expire) begin
      if (tcfg_reg[1]) begin
        tval_next = reload;
      end else begin
        tval_next    = '1;
        stopped_next = 1'b1;
      end
    end else if (active) begin
      tval_next = tval_reg - TIMER_W'(1);
    end
  end

  // Expiry has priority over a same-cycle software clear.
  assign ti_next = expire | (ti_reg & ~(ticlr_we & ticlr_wdata[0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcfg_reg    <= '0;
      tval_reg    <= '0;
      stopped_reg <= 1'b0;
      ti_reg      <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      if (tcfg_we) tcfg_reg <= tcfg_wmask;
      tval_reg    <= tval_next;
      stopped_reg <= stopped_next;
      ti_reg      <= ti_next;
      cnt_reg     <= cnt_reg + 64'd1;
    end
  end

  assign tcfg_out   = tcfg_reg;
  assign ti_out     = ti_reg;
  assign stable_cnt = cnt_reg;

endmodule

// File: tb/tb_csr_timer.sv
// Directed bench for csr_timer: reset, periodic, one-shot, clear race,
// write-vs-expiry, disable and a TIMER_W=8 build.
module tb_csr_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tcfg_we = 1'b0;
  logic [31:0] tcfg_wdata = '0;
  logic        ticlr_we = 1'b0;
  logic [31:0] ticlr_wdata = '0;
  logic [31:0] tcfg_out, tval_out, tcfg_out8, tval_out8;
  logic        ti_out, ti_out8;
  logic [63:0] stable_cnt, stable_cnt8;

  int n_checks = 0;
  int n_fail = 0;
  longint unsigned k = 0;

  csr_timer #(.TIMER_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .tcfg_we(tcfg_we), .tcfg_wdata(tcfg_wdata),
    .ticlr_we(ticlr_we), .ticlr_wdata(ticlr_wdata),
    .tcfg_out(tcfg_out), .tval_out(tval_out),
    .ti_out(ti_out), .stable_cnt(stable_cnt)
  );

  csr_timer #(.TIMER_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .tcfg_we(tcfg_we), .tcfg_wdata(tcfg_wdata),
    .ticlr_we(ticlr_we), .ticlr_wdata(ticlr_wdata),
    .tcfg_out(tcfg_out8), .tval_out(tval_out8),
    .ti_out(ti_out8), .stable_cnt(stable_cnt8)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_tcfg(input logic [31:0] d);
    tcfg_we = 1'b1;
    tcfg_wdata = d;
    tick();
    tcfg_we = 1'b0;
    tcfg_wdata = '0;
  endtask

  task automatic wr_ticlr(input logic [31:0] d);
    ticlr_we = 1'b1;
    ticlr_wdata = d;
    tick();
    ticlr_we = 1'b0;
    ticlr_wdata = '0;
  endtask

  initial begin
    // Reset from time 0
    #1;
    chk("rst_tcfg", 64'(tcfg_out), 64'h0);
    chk("rst_tval", 64'(tval_out), 64'h0);
    chk("rst_ti", 64'(ti_out), 64'h0);
    chk("rst_cnt", stable_cnt, 64'h0);
    tick(2);
    chk("rst_hold_cnt", stable_cnt, 64'h0);
    rst_n = 1'b1;
    k = 0;
    tick();
    chk("cnt_k1", stable_cnt, 64'd1);
    tick();
    chk("cnt_k2", stable_cnt, 64'd2);
    $display("reset: stable_cnt=%0d", stable_cnt);

    // Periodic, initval=2 -> R=8, period 9
    wr_tcfg(32'h0000000B);                       // now N+1
    chk("per_tcfg", 64'(tcfg_out), 64'hB);
    chk("per_tval_n1", 64'(tval_out), 64'd8);
    chk("per_ti_n1", 64'(ti_out), 64'h0);
    tick();                                      // N+2
    chk("per_tval_n2", 64'(tval_out), 64'd7);
    tick(7);                                     // N+9
    chk("per_tval_n9", 64'(tval_out), 64'd0);
    chk("per_ti_n9", 64'(ti_out), 64'h0);
    wr_ticlr(32'h1);                             // clear of idle ti; N+10
    chk("per_ti_n10", 64'(ti_out), 64'h1);
    chk("per_tval_n10", 64'(tval_out), 64'd8);
    chk("cnt_track", stable_cnt, 64'(k));
    wr_ticlr(32'h1);                             // N+11
    chk("per_clr", 64'(ti_out), 64'h0);
    tick(7);                                     // N+18
    chk("per_tval_n18", 64'(tval_out), 64'd0);
    chk("per_ti_n18", 64'(ti_out), 64'h0);
    tick();                                      // N+19
    chk("per_ti_n19", 64'(ti_out), 64'h1);
    chk("per_tval_n19", 64'(tval_out), 64'd8);
    $display("periodic: second expiry seen, ti=%0d tval=%0d", ti_out, tval_out);

    // Clear race, periodic R=4; ti still 1 from before
    wr_tcfg(32'h00000007);                       // W+1
    chk("race_ti_kept", 64'(ti_out), 64'h1);
    chk("race_tval_w1", 64'(tval_out), 64'd4);
    tick(3);                                     // W+4
    chk("race_tval_w4", 64'(tval_out), 64'd1);
    tick();                                      // W+5, tval==0
    chk("race_tval_w5", 64'(tval_out), 64'd0);
    wr_ticlr(32'h1);                             // W+6
    chk("race_set_wins", 64'(ti_out), 64'h1);
    chk("race_tval_w6", 64'(tval_out), 64'd4);
    wr_ticlr(32'hFFFFFFFE);                      // W+7
    chk("race_clr0", 64'(ti_out), 64'h1);
    wr_ticlr(32'h1);                             // W+8
    chk("race_clr1", 64'(ti_out), 64'h0);
    chk("race_tval_w8", 64'(tval_out), 64'd2);
    $display("clear race: ti=%0d", ti_out);

    // Write vs expiry
    tick(2);                                     // W+10, tval==0
    chk("wve_tval0", 64'(tval_out), 64'd0);
    wr_tcfg(32'h00000011);
    chk("wve_ti", 64'(ti_out), 64'h0);
    chk("wve_tval", 64'(tval_out), 64'd16);
    tick();
    chk("wve_dec", 64'(tval_out), 64'd15);
    $display("write vs expiry: tval=%0d ti=%0d", tval_out, ti_out);

    // One-shot, R=4
    wr_tcfg(32'h00000005);                       // O+1
    chk("os_tval_o1", 64'(tval_out), 64'd4);
    tick(4);                                     // O+5
    chk("os_tval_o5", 64'(tval_out), 64'd0);
    chk("os_ti_o5", 64'(ti_out), 64'h0);
    tick();                                      // O+6
    chk("os_ti_o6", 64'(ti_out), 64'h1);
    chk("os_tval_o6", 64'(tval_out), 64'hFFFFFFFF);
    wr_ticlr(32'h1);
    for (int i = 0; i < 50; i++) begin
      chk("os_hold_tval", 64'(tval_out), 64'hFFFFFFFF);
      chk("os_hold_ti", 64'(ti_out), 64'h0);
      tick();
    end
    wr_tcfg(32'h00000005);
    chk("os_restart", 64'(tval_out), 64'd4);
    tick();
    chk("os_restart_dec", 64'(tval_out), 64'd3);
    $display("one-shot: restarted tval=%0d", tval_out);

    // Disabled timer
    wr_tcfg(32'h0000001C);
    chk("dis_tcfg", 64'(tcfg_out), 64'h1C);
    chk("dis_tval", 64'(tval_out), 64'd28);
    tick(10);
    chk("dis_frozen", 64'(tval_out), 64'd28);
    chk("dis_ti", 64'(ti_out), 64'h0);
    $display("disabled: tval=%0d", tval_out);

    // Width: both builds see 0xFFFFFFFF
    wr_tcfg(32'hFFFFFFFF);
    chk("w8_tcfg", 64'(tcfg_out8), 64'hFF);
    chk("w8_tval", 64'(tval_out8), 64'hFC);
    chk("w32_tcfg", 64'(tcfg_out), 64'hFFFFFFFF);
    chk("w32_tval", 64'(tval_out), 64'hFFFFFFFC);
    tick();
    chk("w8_dec", 64'(tval_out8), 64'hFB);
    $display("width: tcfg8=%0h tval8=%0h", tcfg_out8, tval_out8);

    // Mid-count reset with ti=1, tval=5
    wr_tcfg(32'h0000000B);                       // tval 8
    tick(8);                                     // tval 0
    tick();                                      // expiry: ti=1, tval 8
    chk("mr_ti_pre", 64'(ti_out), 64'h1);
    tick(3);
    chk("mr_tval_pre", 64'(tval_out), 64'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_tcfg", 64'(tcfg_out), 64'h0);
    chk("mr_tval", 64'(tval_out), 64'h0);
    chk("mr_ti", 64'(ti_out), 64'h0);
    chk("mr_cnt", stable_cnt, 64'h0);
    tick();
    rst_n = 1'b1;
    k = 0;
    tick();
    chk("mr_cnt1", stable_cnt, 64'd1);
    chk("mr_no_ti", 64'(ti_out), 64'h0);
    tick(5);
    chk("mr_idle_ti", 64'(ti_out), 64'h0);
    chk("mr_idle_tval", 64'(tval_out), 64'h0);
    chk("mr_cnt6", stable_cnt, 64'(k));
    $display("mid reset: stable_cnt=%0d ti=%0d", stable_cnt, ti_out);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_timer.md
# csr_timer

Constant timer and stable counter for the CSR file. Holds the TCFG and TVAL registers, counts TVAL down, and latches the timer interrupt. The latched interrupt drives the exception stage's `ti_in`, and CSR writes to TICLR clear it. A free-running 64-bit stable counter is also kept here and read by the `rdcnt*` instructions in the execute stage.

## Interface
Parameters:
- `TIMER_W`, default 32: implemented TVAL/initval width, legal range 8..32. Bits above `TIMER_W` read as 0.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `tcfg_we` in 1: TCFG write strobe from the CSR write path, single-cycle.
- `tcfg_wdata` in 32: TCFG write data.
  - bit0 = `en`.
  - bit1 = `periodic`.
  - bits[`TIMER_W`-1:2] = `initval`.
  - Other bits are ignored and store 0.
- `ticlr_we` in 1: TICLR write strobe.
- `ticlr_wdata` in 32: bit0 = `clr`. Other bits are ignored.
- `tcfg_out` out 32: current TCFG value.
- `tval_out` out 32: current TVAL, zero-extended from `TIMER_W`.
- `ti_out` out 1: pending timer interrupt (ESTAT.IS[11]), registered.
- `stable_cnt` out 64: free-running stable counter.

## Operation
- **Internal state:**
  - `tcfg` register, 32 bits.
  - `tval` register, `TIMER_W` bits.
  - `stopped` flag, 1 bit.
  - `ti` flag, 1 bit.
  - `cnt` register, 64 bits.
- **Reload value:** R = {`initval`, 2'b00}, `TIMER_W` bits.
- **Active:** `tcfg.en` & ~`stopped`.
- **Per-cycle update of `tval`/`stopped`, in priority order:**
  1. If `tcfg_we`:
     - `tcfg` <= masked `tcfg_wdata`.
     - `tval` <= {`tcfg_wdata.initval`, 2'b00}.
     - `stopped` <= 0.
     - No expiry event this cycle.
  2. Else if active & `tval` == 0 (expiry event):
     - `periodic` = 1: `tval` <= R.
     - `periodic` = 0: `tval` <= all-ones and `stopped` <= 1.
  3. Else if active: `tval` <= `tval` - 1.
  4. Else: hold.
- **`ti`:**
  - Set on an expiry event.
  - Otherwise cleared when `ticlr_we` & `ticlr_wdata[0]`.
  - Set wins over a same-cycle clear.
  - A clear with bit0 = 0 has no effect.
  - `ti` is not affected by `tcfg_we`; software must clear it explicitly.
- **`cnt`:** increments by 1 every cycle, unconditionally. Wraps from 2^64-1 to 0.
- **Output mapping:**
  - `tcfg_out` = `tcfg`.
  - `tval_out` = {zeros, `tval`}.
  - `ti_out` = `ti`.
  - `stable_cnt` = `cnt`.
- **Disabled timer** (`en` = 0): `tval` frozen and no events. Re-enabling is only possible through a TCFG write, which also reloads `tval`.
- **One-shot expiry:** `tval` stays at all-ones, no further events, until the next TCFG write.
- **Reset** (`rst_n` low, asynchronous):
  - `tcfg` = 0, `tval` = 0, `stopped` = 0, `ti` = 0, `cnt` = 0.
  - Therefore `tcfg_out` = 0, `tval_out` = 0, `ti_out` = 0, `stable_cnt` = 0.
  - Reset mid-count discards all state. There is no event on reset release.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- TCFG write in cycle N:
  - `tcfg_out` and `tval_out` show the new values from N+1.
  - First decrement lands at N+2.
- Expiry: `tval` == 0 observed in cycle M gives `ti_out` = 1 from M+1, with `tval_out` reloaded (or all-ones) at M+1 in the same edge.
- Periodic period = R + 1 cycles between expiry events.
- TICLR write in cycle N: `ti_out` = 0 at N+1, unless an expiry event also occurs in N.
- `stable_cnt` reads k at cycle k after reset release.
- TCFG and TICLR writes in the same cycle are independent; both take effect.

## Test plan
- **Reset:**
  - Stimulus: assert `rst_n` low mid-count (`tval` = 5, `ti` = 1), then release.
  - Required response: all outputs 0 immediately on assertion; `stable_cnt` = 1 one cycle after release; no `ti_out`.
- **Periodic:**
  - Stimulus: `tcfg_wdata` = 0x0000000B at cycle N (`en`, `periodic`, `initval` = 2).
  - Required response:
    - `tval_out` = 8 at N+1 and 0 at N+9.
    - `ti_out` = 1 and `tval_out` = 8 at N+10.
    - Next expiry at N+19.
- **One-shot:**
  - Stimulus: `tcfg_wdata` = 0x00000005 (`en`, `initval` = 1, R = 4) at N.
  - Required response:
    - `tval_out` = 0 at N+5.
    - `ti_out` = 1 and `tval_out` = 0xFFFFFFFF at N+6.
    - `tval_out` is held and no further event over 50 cycles.
    - A new TCFG write restarts the count.
- **Clear race:**
  - Stimulus: with `ti` = 1, periodic R = 4, issue TICLR clr = 1 in the cycle `tval` == 0.
  - Required response: `ti_out` stays 1. A TICLR clr = 1 one cycle later gives `ti_out` = 0. TICLR with bit0 = 0 leaves `ti_out` unchanged.
- **Write-vs-expiry:**
  - Stimulus: TCFG write of 0x00000011 (`en`, R = 16) in the cycle `tval` == 0.
  - Required response: no `ti` set; `tval_out` = 16 next cycle.
- **Disable and width:**
  - Stimulus:
    - `tcfg` `en` = 0 write with `initval` = 7: `tval_out` = 28, frozen.
    - `TIMER_W` = 8 build, write 0xFFFFFFFF.
  - Required response: for the `TIMER_W` = 8 build, `tcfg_out` = 0x000000FF and `tval_out` = 0x000000FC.
